// File: rtl/mem_burst_master_if.sv
// Single-word read/write port into main memory. The master drives the request;
// the memory answers with rdy, and read data arrives one cycle after an accepted read.
interface mem_rwport #(
  parameter int AW = 8,
  parameter int DW = 16
);
  logic          val;
  logic          wen;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          rdy;

  modport master (output val, wen, addr, wdata, input rdata, rdy);
  modport slave  (input val, wen, addr, wdata, output rdata, rdy);
endinterface

// File: rtl/mem_burst_master.sv
// Burst master for main memory: a load streams words into memory, a dump reads a
// range back out as a word stream, one memory transaction per word.
//
// state     | meaning
// S_IDLE    | waiting for a command, cmd_rdy_o high
// S_WR      | load words pass straight through to the memory write port
// S_RD_REQ  | read request for cur_addr held on the port until rdy
// S_RD_WAIT | memory returns rdata this cycle; capture it
// S_RD_OUT  | captured word presented on rd_* until downstream accepts
module mem_burst_master #(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          cmd_val_i,
  output logic          cmd_rdy_o,
  input  logic          cmd_op_i,
  input  logic [AW-1:0] cmd_addr_i,
  input  logic [AW-1:0] cmd_len_i,
  input  logic          wd_val_i,
  output logic          wd_rdy_o,
  input  logic [DW-1:0] wd_data_i,
  output logic          rd_val_o,
  input  logic          rd_rdy_i,
  output logic [DW-1:0] rd_data_o,
  output logic          rd_last_o,
  output logic          busy_o,
  mem_rwport.master     rw_intf
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD_REQ,
    S_RD_WAIT,
    S_RD_OUT
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_cur_addr;
  logic [AW-1:0] w_cur_addr_nxt;
  logic [AW-1:0] r_remaining;
  logic [AW-1:0] w_remaining_nxt;
  logic [DW-1:0] r_rd_data;
  logic [DW-1:0] w_rd_data_nxt;
  logic          r_rd_last;
  logic          w_rd_last_nxt;

  logic          w_cmd_rdy;
  logic          w_wd_rdy;
  logic          w_rd_val;
  logic          w_mem_val;
  logic          w_mem_wen;
  logic [AW-1:0] w_mem_addr;
  logic [DW-1:0] w_mem_wdata;
  logic          w_last_word;

  assign w_last_word = (r_remaining == '0);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state     <= S_IDLE;
      r_cur_addr  <= '0;
      r_remaining <= '0;
      r_rd_data   <= '0;
      r_rd_last   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cur_addr  <= w_cur_addr_nxt;
      r_remaining <= w_remaining_nxt;
      r_rd_data   <= w_rd_data_nxt;
      r_rd_last   <= w_rd_last_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cur_addr_nxt  = r_cur_addr;
    w_remaining_nxt = r_remaining;
    w_rd_data_nxt   = r_rd_data;
    w_rd_last_nxt   = r_rd_last;
    w_cmd_rdy       = 1'b0;
    w_wd_rdy        = 1'b0;
    w_rd_val        = 1'b0;
    w_mem_val       = 1'b0;
    w_mem_wen       = 1'b0;
    w_mem_addr      = '0;
    w_mem_wdata     = '0;

    unique case (r_state)
      S_IDLE: begin
        w_cmd_rdy = 1'b1;
        if (cmd_val_i) begin
          w_cur_addr_nxt  = cmd_addr_i;
          w_remaining_nxt = cmd_len_i;
          w_state_nxt     = cmd_op_i ? S_RD_REQ : S_WR;
        end
      end
      S_WR: begin
        // Unbuffered pass-through: the data stream sees the memory's rdy directly.
        w_mem_val   = wd_val_i;
        w_mem_wen   = 1'b1;
        w_mem_addr  = r_cur_addr;
        w_mem_wdata = wd_data_i;
        w_wd_rdy    = rw_intf.rdy;
        if (wd_val_i && rw_intf.rdy) begin
          if (w_last_word) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_cur_addr_nxt  = r_cur_addr + AW'(1);
            w_remaining_nxt = r_remaining - AW'(1);
          end
        end
      end
      S_RD_REQ: begin
        w_mem_val  = 1'b1;
        w_mem_addr = r_cur_addr;
        if (rw_intf.rdy) w_state_nxt = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        w_rd_data_nxt = rw_intf.rdata;
        w_rd_last_nxt = w_last_word;
        w_state_nxt   = S_RD_OUT;
      end
      S_RD_OUT: begin
        w_rd_val = 1'b1;
        if (rd_rdy_i) begin
          if (w_last_word) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_cur_addr_nxt  = r_cur_addr + AW'(1);
            w_remaining_nxt = r_remaining - AW'(1);
            w_state_nxt     = S_RD_REQ;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign cmd_rdy_o     = w_cmd_rdy;
  assign wd_rdy_o      = w_wd_rdy;
  assign rd_val_o      = w_rd_val;
  assign rd_data_o     = r_rd_data;
  assign rd_last_o     = r_rd_last && (r_state == S_RD_OUT);
  assign busy_o        = (r_state != S_IDLE);
  assign rw_intf.val   = w_mem_val;
  assign rw_intf.wen   = w_mem_wen;
  assign rw_intf.addr  = w_mem_addr;
  assign rw_intf.wdata = w_mem_wdata;

endmodule

// File: tb/tb_mem_burst_master.sv
// Directed bench for mem_burst_master: a behavioural memory on the rw port and
// write/read scoreboards fed from the stimulus, checked as the DUT handshakes.
module tb_mem_burst_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_val;
  logic        cmd_rdy;
  logic        cmd_op;
  logic [7:0]  cmd_addr;
  logic [7:0]  cmd_len;
  logic        wd_val;
  logic        wd_rdy;
  logic [15:0] wd_data;
  logic        rd_val;
  logic        rd_rdy;
  logic [15:0] rd_data;
  logic        rd_last;
  logic        busy;
  logic        mem_rdy;
  logic [15:0] mem_rdata = '0;
  logic [15:0] mem [256];
  logic [15:0] shadow [256];
  logic [15:0] ld_data [4];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic [23:0] wq[$];
  logic [16:0] rq[$];

  mem_rwport #(.AW(8), .DW(16)) rw ();

  assign rw.rdy   = mem_rdy;
  assign rw.rdata = mem_rdata;

  mem_burst_master #(.AW(8), .DW(16)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_val_i(cmd_val), .cmd_rdy_o(cmd_rdy), .cmd_op_i(cmd_op),
    .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len),
    .wd_val_i(wd_val), .wd_rdy_o(wd_rdy), .wd_data_i(wd_data),
    .rd_val_o(rd_val), .rd_rdy_i(rd_rdy), .rd_data_o(rd_data), .rd_last_o(rd_last),
    .busy_o(busy), .rw_intf(rw)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rw.val && rw.rdy) begin
      if (rw.wen) mem[rw.addr] <= rw.wdata;
      else        mem_rdata    <= mem[rw.addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every memory write and every accepted dump word is popped here.
  always @(negedge clk) begin
    logic [23:0] we;
    logic [16:0] re;
    if (rst_n && rw.val && mem_rdy && rw.wen) begin
      checks++;
      assert (wq.size() > 0) else begin
        failures++;
        $error("FAIL wr_unexpected observed_addr=%0h expected=none", rw.addr);
      end
      if (wq.size() > 0) begin
        we = wq.pop_front();
        chk("wr_addr", 32'(rw.addr), 32'(we[23:16]));
        chk("wr_data", 32'(rw.wdata), 32'(we[15:0]));
      end
    end
    if (rst_n && rd_val && rd_rdy) begin
      checks++;
      assert (rq.size() > 0) else begin
        failures++;
        $error("FAIL rd_unexpected observed_data=%0h expected=none", rd_data);
      end
      if (rq.size() > 0) begin
        re = rq.pop_front();
        chk("rd_data", 32'(rd_data), 32'(re[15:0]));
        chk("rd_last", 32'(rd_last), 32'(re[16]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_cmd(input logic op, input logic [7:0] a, input logic [7:0] l);
    int t;
    t = 0;
    cmd_val = 1'b1; cmd_op = op; cmd_addr = a; cmd_len = l;
    #1;
    while (!cmd_rdy && t < 50) begin step(); t++; end
    chk("cmd_accept_timeout", 32'(t < 50), 32'd1);
    chk("wd_rdy_in_cmd_cycle", 32'(wd_rdy), 32'd0);
    step();
    cmd_val = 1'b0;
  endtask

  task automatic load(input logic [7:0] a, input logic [7:0] l, input bit stall);
    int i;
    int t;
    logic [7:0] ad;
    for (int k = 0; k <= int'(l); k++) begin
      ad = a + 8'(k);
      shadow[ad] = ld_data[k];
      wq.push_back({ad, ld_data[k]});
    end
    wd_val = 1'b1; wd_data = ld_data[0];
    issue_cmd(1'b0, a, l);
    i = 0; t = 0;
    while (i <= int'(l) && t < 200) begin
      wd_val  = stall ? (t % 3 != 1) : 1'b1;
      mem_rdy = stall ? (t % 2 == 0) : 1'b1;
      wd_data = ld_data[i];
      if (stall) begin
        cmd_val = 1'b1; cmd_op = 1'b1; cmd_addr = a; cmd_len = l;
      end
      #1;
      chk("wr_wd_rdy_follows_mem", 32'(wd_rdy), 32'(mem_rdy));
      chk("wr_cmd_rdy_low", 32'(cmd_rdy), 32'd0);
      if (wd_val && mem_rdy) i++;
      step();
      t++;
    end
    chk("load_timeout", 32'(t < 200), 32'd1);
    if (!stall) chk("load_cycles", 32'(t), 32'(int'(l) + 1));
    wd_val = 1'b0; mem_rdy = 1'b1;
    #1;
    chk("load_busy_done", 32'(busy), 32'd0);
    chk("load_cmd_rdy_done", 32'(cmd_rdy), 32'd1);
  endtask

  task automatic dump(input logic [7:0] a, input logic [7:0] l, input int bp_word,
                      input int bp_cyc, input bit skip_cmd);
    int t;
    int prev;
    logic [7:0] ad;
    for (int k = 0; k <= int'(l); k++) begin
      ad = a + 8'(k);
      rq.push_back({(k == int'(l)), shadow[ad]});
    end
    if (!skip_cmd) issue_cmd(1'b1, a, l);
    prev = 0;
    for (int w = 0; w <= int'(l); w++) begin
      rd_rdy = (w != bp_word);
      #1;
      t = 0;
      while (!rd_val && t < 20) begin step(); t++; end
      chk("rd_val_timeout", 32'(t < 20), 32'd1);
      if (bp_word < 0 && w > 0) chk("rd_spacing", 32'(cyc - prev), 32'd3);
      prev = cyc;
      if (w == bp_word) begin
        ad = a + 8'(w);
        for (int c = 0; c < bp_cyc; c++) begin
          step();
          chk("bp_rd_val_held", 32'(rd_val), 32'd1);
          chk("bp_rd_data_stable", 32'(rd_data), 32'(shadow[ad]));
          chk("bp_no_mem_val", 32'(rw.val), 32'd0);
        end
        rd_rdy = 1'b1;
      end
      step();
    end
    #1;
    chk("dump_busy_done", 32'(busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "global timeout");
  end

  initial begin
    for (int k = 0; k < 256; k++) begin mem[k] = '0; shadow[k] = '0; end
    rst_n = 1'b0; cmd_val = 1'b0; cmd_op = 1'b0; cmd_addr = '0; cmd_len = '0;
    wd_val = 1'b0; wd_data = '0; rd_rdy = 1'b1; mem_rdy = 1'b1;
    repeat (3) step();
    chk("rst_cmd_rdy", 32'(cmd_rdy), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wd_rdy", 32'(wd_rdy), 32'd0);
    chk("rst_rd_val", 32'(rd_val), 32'd0);
    chk("rst_rd_last", 32'(rd_last), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_mem_val", 32'(rw.val), 32'd0);
    chk("rst_mem_wen", 32'(rw.wen), 32'd0);
    chk("rst_mem_addr", 32'(rw.addr), 32'd0);
    chk("rst_mem_wdata", 32'(rw.wdata), 32'd0);
    rst_n = 1'b1;
    step();

    ld_data[0] = 16'h1111; ld_data[1] = 16'h2222; ld_data[2] = 16'h3333; ld_data[3] = 16'h4444;
    load(8'h10, 8'd3, 1'b0);
    dump(8'h10, 8'd3, -1, 0, 1'b0);

    ld_data[0] = 16'h00A0; ld_data[1] = 16'h00A1; ld_data[2] = 16'h00A2; ld_data[3] = 16'h00A3;
    load(8'hFE, 8'd3, 1'b0);
    chk("wrap_mem_fe", 32'(mem[8'hFE]), 32'h00A0);
    chk("wrap_mem_ff", 32'(mem[8'hFF]), 32'h00A1);
    chk("wrap_mem_00", 32'(mem[8'h00]), 32'h00A2);
    chk("wrap_mem_01", 32'(mem[8'h01]), 32'h00A3);
    dump(8'hFE, 8'd3, -1, 0, 1'b0);

    dump(8'h10, 8'd3, 1, 5, 1'b0);

    ld_data[0] = 16'hB0B0; ld_data[1] = 16'hB1B1; ld_data[2] = 16'hB2B2; ld_data[3] = 16'hB3B3;
    load(8'h40, 8'd3, 1'b1);
    step();
    cmd_val = 1'b0;
    #1;
    chk("queued_cmd_busy", 32'(busy), 32'd1);
    chk("queued_cmd_rd_req", 32'(rw.val & ~rw.wen), 32'd1);
    chk("queued_cmd_addr", 32'(rw.addr), 32'h40);
    dump(8'h40, 8'd3, -1, 0, 1'b1);

    cmd_val = 1'b1; cmd_op = 1'b1; cmd_addr = 8'h10; cmd_len = 8'd3;
    step();
    cmd_val = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_rd_val", 32'(rd_val), 32'd0);
    chk("midrst_mem_val", 32'(rw.val), 32'd0);
    chk("midrst_cmd_rdy", 32'(cmd_rdy), 32'd1);
    dump(8'h13, 8'd0, -1, 0, 1'b0);

    repeat (3) step();
    chk("wq_drained", 32'(wq.size()), 32'd0);
    chk("rq_drained", 32'(rq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
